// File: rtl/pwf_multi_pkg.sv
// Shared types for the multi-channel pulse-width filter.
// Holds the per-channel FSM state encoding and the output mode codes.
package pwf_pkg;

    typedef enum logic [1:0] {
        LOW,
        QUAL_H,
        HIGH,
        QUAL_L
    } pwf_state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/pwf_multi_if.sv
// Signal bundle between control logic (master) and the filter (slave).
// a/t_on/t_off/mode flow to the filter; c/len/len_vld flow back.
interface pwf_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);

    logic [N_CH-1:0]       a;
    logic [CNT_W-1:0]      t_on;
    logic [CNT_W-1:0]      t_off;
    logic                  mode;
    logic [N_CH-1:0]       c;
    logic [N_CH*CNT_W-1:0] len;
    logic [N_CH-1:0]       len_vld;

    modport master (
        output a, t_on, t_off, mode,
        input  c, len, len_vld
    );

    modport slave (
        input  a, t_on, t_off, mode,
        output c, len, len_vld
    );

endinterface

// File: rtl/pwf_multi_ch.sv
// One filter channel: optional synchroniser, qualify FSM, width counter.
// Ports: i_clk, i_rst, i_a, i_t_on, i_t_off, i_mode -> o_c, o_len, o_len_vld.
module pwf_ch
    import pwf_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a,
    input  logic [CNT_W-1:0] i_t_on,
    input  logic [CNT_W-1:0] i_t_off,
    input  logic             i_mode,
    output logic             o_c,
    output logic [CNT_W-1:0] o_len,
    output logic             o_len_vld
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic w_as;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_as = i_a;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) r_sync <= '0;
                else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_a};
            end
            assign w_as = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    pwf_state_t       r_state;
    pwf_state_t       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_len;
    logic             r_len_vld;
    logic             r_c;
    logic             w_c_nx;

    logic [CNT_W-1:0] w_thr_on;
    logic [CNT_W-1:0] w_thr_off;
    logic [CNT_W:0]   w_cnt_nx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_on_ok;
    logic             w_off_ok;
    logic             w_fall;

    assign w_thr_on  = (i_t_on  == '0) ? CNT_W'(1) : i_t_on;
    assign w_thr_off = (i_t_off == '0) ? CNT_W'(1) : i_t_off;

    // Compare in CNT_W+1 bits so cnt+1 never wraps before the compare.
    assign w_cnt_nx  = {1'b0, r_cnt} + 1'b1;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : w_cnt_nx[CNT_W-1:0];
    assign w_on_ok   = (w_cnt_nx >= {1'b0, w_thr_on});
    assign w_off_ok  = (w_cnt_nx >= {1'b0, w_thr_off});

    // LOW behaves as QUAL_H with cnt=0, HIGH as QUAL_L with cnt=0.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_d    = r_cnt;
        unique case (r_state)
            LOW, QUAL_H: begin
                if (w_as) begin
                    if (w_on_ok) begin
                        w_state_nx = HIGH;
                        w_cnt_d    = '0;
                    end else begin
                        w_state_nx = QUAL_H;
                        w_cnt_d    = w_cnt_inc;
                    end
                end else begin
                    w_state_nx = LOW;
                    w_cnt_d    = '0;
                end
            end
            HIGH, QUAL_L: begin
                if (!w_as) begin
                    if (w_off_ok) begin
                        w_state_nx = LOW;
                        w_cnt_d    = '0;
                    end else begin
                        w_state_nx = QUAL_L;
                        w_cnt_d    = w_cnt_inc;
                    end
                end else begin
                    w_state_nx = HIGH;
                    w_cnt_d    = '0;
                end
            end
            default: begin
                w_state_nx = LOW;
                w_cnt_d    = '0;
            end
        endcase
    end

    always_comb begin
        w_c_nx = 1'b0;
        if (i_mode == MODE_PULSE) begin
            w_c_nx = ((r_state == LOW) || (r_state == QUAL_H))
                     && (w_state_nx == HIGH);
        end else begin
            w_c_nx = (w_state_nx == HIGH) || (w_state_nx == QUAL_L);
        end
    end

    // hcnt is non-zero only after a high sample, so it doubles as 'previous as'.
    assign w_fall = !w_as && (r_hcnt != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= LOW;
            r_cnt     <= '0;
            r_c       <= 1'b0;
            r_hcnt    <= '0;
            r_len     <= '0;
            r_len_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_d;
            r_c       <= w_c_nx;
            r_len_vld <= w_fall;
            if (w_as) begin
                r_hcnt <= (r_hcnt == CNT_MAX) ? CNT_MAX : r_hcnt + 1'b1;
            end else begin
                r_hcnt <= '0;
            end
            if (w_fall) r_len <= r_hcnt;
        end
    end

    assign o_c       = r_c;
    assign o_len     = r_len;
    assign o_len_vld = r_len_vld;

endmodule

// File: rtl/pwf_multi.sv
// Multi-channel pulse-width filter: N_CH independent pwf_ch instances.
// Ports: clk4m, rst (async, active-high), bus (slave: a/t_on/t_off/mode in, c/len/len_vld out).
module pwf_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 0
) (
    input  logic         clk4m,
    input  logic         rst,
    pwf_multi_if.slave   bus
);

    // Reset asserts immediately but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge clk4m or posedge rst) begin
        if (rst) r_rst_sync <= 2'b11;
        else     r_rst_sync <= {r_rst_sync[0], 1'b0};
    end

    assign w_rst = r_rst_sync[1];

    logic [N_CH-1:0]       w_c;
    logic [N_CH*CNT_W-1:0] w_len;
    logic [N_CH-1:0]       w_len_vld;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwf_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .i_clk     (clk4m),
            .i_rst     (w_rst),
            .i_a       (bus.a[i]),
            .i_t_on    (bus.t_on),
            .i_t_off   (bus.t_off),
            .i_mode    (bus.mode),
            .o_c       (w_c[i]),
            .o_len     (w_len[i*CNT_W +: CNT_W]),
            .o_len_vld (w_len_vld[i])
        );
    end

    assign bus.c       = w_c;
    assign bus.len     = w_len;
    assign bus.len_vld = w_len_vld;

endmodule

// File: tb/tb_pwf_multi.sv
// Testbench for pwf_multi: directed scenarios plus randomized traffic
// checked every cycle against a run-length reference model.
module tb_pwf_multi;

    localparam int N_CH  = 2;
    localparam int CNT_W = 8;

    logic clk4m = 1'b0;
    logic rst;

    always #125 clk4m = ~clk4m;

    pwf_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    pwf_multi #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (0)
    ) dut (
        .clk4m (clk4m),
        .rst   (rst),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: filtered level flips after thr consecutive disagreeing samples.
    logic [N_CH-1:0]       m_lvl;
    int                    m_dis [N_CH];
    int                    m_run [N_CH];
    logic [N_CH-1:0]       exp_c;
    logic [N_CH-1:0]       exp_vld;
    logic [N_CH*CNT_W-1:0] exp_len;

    logic [7:0] last_len0;
    int         n_strb0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_lvl   = '0;
        exp_c   = '0;
        exp_vld = '0;
        exp_len = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_dis[ch] = 0;
            m_run[ch] = 0;
        end
    endtask

    task automatic model_step();
        for (int ch = 0; ch < N_CH; ch++) begin
            int   thr;
            logic s;
            logic rose;
            s    = bus.a[ch];
            rose = 1'b0;
            if (m_lvl[ch])
                thr = (bus.t_off == 0) ? 1 : int'(bus.t_off);
            else
                thr = (bus.t_on == 0) ? 1 : int'(bus.t_on);
            if (s != m_lvl[ch]) begin
                m_dis[ch]++;
                if (m_dis[ch] >= thr) begin
                    rose      = s;
                    m_lvl[ch] = s;
                    m_dis[ch] = 0;
                end
            end else begin
                m_dis[ch] = 0;
            end
            exp_c[ch] = bus.mode ? rose : m_lvl[ch];
            if (s) begin
                m_run[ch]++;
                exp_vld[ch] = 1'b0;
            end else begin
                exp_vld[ch] = (m_run[ch] > 0);
                if (m_run[ch] > 0)
                    exp_len[ch*CNT_W +: CNT_W] =
                        8'((m_run[ch] > 255) ? 255 : m_run[ch]);
                m_run[ch] = 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk4m);
        model_step();
        @(negedge clk4m);
        chk("c", 32'(bus.c), 32'(exp_c));
        chk("len_vld", 32'(bus.len_vld), 32'(exp_vld));
        chk("len", 32'(bus.len), 32'(exp_len));
        if (bus.len_vld[0]) begin
            last_len0 = bus.len[7:0];
            n_strb0++;
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int first_hi;
    int first_lo;
    int n_hi0;
    int n_hi1;

    initial begin
        bus.a     = '0;
        bus.t_on  = 8'd10;
        bus.t_off = 8'd10;
        bus.mode  = 1'b0;
        last_len0 = '0;
        n_strb0   = 0;
        rst       = 1'b1;
        model_reset();
        #10;
        chk("rst_c", 32'(bus.c), 32'd0);
        chk("rst_len", 32'(bus.len), 32'd0);
        chk("rst_vld", 32'(bus.len_vld), 32'd0);
        @(negedge clk4m);
        @(negedge clk4m);
        rst = 1'b0;
        run_n(4);

        // 1: 13 high then low, level mode
        bus.a[0] = 1'b1;
        first_hi = -1;
        for (int i = 1; i <= 13; i++) begin
            cyc();
            if (bus.c[0] && first_hi < 0) first_hi = i;
        end
        chk("t1_rise_edge", 32'(first_hi), 32'd10);
        bus.a[0] = 1'b0;
        first_lo = -1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (!bus.c[0] && first_lo < 0) first_lo = i;
        end
        chk("t1_fall_edge", 32'(first_lo), 32'd10);
        chk("t1_len", 32'(last_len0), 32'd13);

        // 2: 9 high is rejected
        bus.a[0] = 1'b1;
        n_hi0 = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (bus.c[0]) n_hi0++;
        end
        bus.a[0] = 1'b0;
        run_n(2);
        chk("t2_no_c", 32'(n_hi0), 32'd0);
        chk("t2_len", 32'(last_len0), 32'd9);

        // 3: 6 high, 1 low, 6 high, 1 low, then 10 high
        n_strb0 = 0;
        n_hi0   = 0;
        for (int seg = 0; seg < 4; seg++) begin
            bus.a[0] = (seg % 2 == 0);
            for (int i = 0; i < ((seg % 2 == 0) ? 6 : 1); i++) begin
                cyc();
                if (bus.c[0]) n_hi0++;
            end
        end
        chk("t3_no_c", 32'(n_hi0), 32'd0);
        chk("t3_strobes", 32'(n_strb0), 32'd2);
        chk("t3_len", 32'(last_len0), 32'd6);
        bus.a[0] = 1'b1;
        run_n(10);
        chk("t3_c_on", 32'(bus.c[0]), 32'd1);
        bus.a[0] = 1'b0;
        run_n(12);

        // 4: pulse mode on channel 1
        bus.mode = 1'b1;
        bus.a[1] = 1'b1;
        n_hi0    = 0;
        n_hi1    = 0;
        first_hi = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (bus.c[1]) n_hi1++;
            if (bus.c[0]) n_hi0++;
            if (bus.c[1] && first_hi < 0) first_hi = i;
        end
        chk("t4_pulse_cnt", 32'(n_hi1), 32'd1);
        chk("t4_pulse_edge", 32'(first_hi), 32'd10);
        chk("t4_ch0_quiet", 32'(n_hi0), 32'd0);
        bus.a[1] = 1'b0;
        run_n(12);
        bus.mode = 1'b0;

        // 5: reset mid-cycle while c[0]=1
        bus.a[0] = 1'b1;
        run_n(12);
        chk("t5_c_before", 32'(bus.c[0]), 32'd1);
        #60;
        rst      = 1'b1;
        bus.a    = '0;
        model_reset();
        #1;
        chk("t5_rst_c", 32'(bus.c), 32'd0);
        chk("t5_rst_len", 32'(bus.len), 32'd0);
        run_n(2);
        rst = 1'b0;
        run_n(3);
        bus.a[0] = 1'b1;
        first_hi = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (bus.c[0] && first_hi < 0) first_hi = i;
        end
        chk("t5_requal", 32'(first_hi), 32'd10);
        bus.a[0] = 1'b0;
        run_n(12);

        // 6: saturation, then t_on=0 single sample
        bus.a[0] = 1'b1;
        run_n(300);
        bus.a[0] = 1'b0;
        cyc();
        chk("t6_len_sat", 32'(last_len0), 32'd255);
        run_n(11);
        bus.t_on = 8'd0;
        bus.a[0] = 1'b1;
        cyc();
        chk("t6_ton0", 32'(bus.c[0]), 32'd1);
        bus.a[0] = 1'b0;
        run_n(12);

        // randomized traffic with changing thresholds and mode
        for (int k = 0; k < 600; k++) begin
            if (k % 50 == 0) begin
                bus.t_on  = 8'($urandom_range(0, 7));
                bus.t_off = 8'($urandom_range(0, 7));
                bus.mode  = 1'($urandom_range(0, 1));
            end
            for (int ch = 0; ch < N_CH; ch++)
                if ($urandom_range(0, 3) == 0) bus.a[ch] = ~bus.a[ch];
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
